gcd_sequencer: RTL and testbench
================================

// Module: gcd_sequencer
// PURPOSE
//  Multi-cycle controller that sequences one ALU instance (subtract + comparator)
//  to compute GCD(i_a, i_b) by Euclid's repeated-subtraction method.
//  Sits between a requester (start/done handshake) and the shared ALU datapath.
//  It owns the ALU inputs and computes one compare or one subtract per cycle.
// PARAMETERS
//  BITS   8   operand / result width; passed to the ALU instance as BITS
// PORTS
//  i_clk     in   1     clock; all state updates on rising edge
//  i_rst     in   1     synchronous reset, active-high
//  i_start   in   1     request; sampled only in IDLE
//  i_a       in   BITS  operand A; captured in the cycle i_start is accepted
//  i_b       in   BITS  operand B; captured in the cycle i_start is accepted
//  o_busy    out  1     high in CMP and SUB states
//  o_done    out  1     one-cycle pulse in DONE state
//  o_result  out  BITS  GCD; valid from the o_done cycle, held until next accept
//  o_steps   out  BITS  count of SUB cycles used by the last job
//  o_err     out  1     set with o_done when both operands were 0; held like o_result
// BEHAVIOUR
//  - Reset: state=IDLE; o_busy=0, o_done=0, o_result=0, o_steps=0, o_err=0;
//    internal a_reg, b_reg and dir are cleared. Reset mid-job abandons the job with no o_done.
//  - ALU contract relied on: o_out_sub = (i_a - i_b - i_carry) mod 2^BITS;
//    o_carry = 1 when a borrow occurs (i_a < i_b + i_carry). i_carry is always driven 0.
//  - FSM states: IDLE, CMP, SUB, DONE.
//  - IDLE: on i_start, load a_reg=i_a, b_reg=i_b and clear the step count.
//      if both operands are 0 -> DONE with result=0, err=1
//      else if exactly one is 0 -> DONE with result = the nonzero operand, err=0
//      else -> CMP
//  - CMP: ALU inputs are (a_reg, b_reg).
//      borrow=0 and diff=0 -> DONE with result=a_reg
//      borrow=0 -> dir=0 (A is larger), go to SUB
//      borrow=1 -> dir=1 (B is larger), go to SUB
//  - SUB: dir=0 drives ALU (a_reg, b_reg) and writes a_reg <= o_out_sub.
//    dir=1 drives ALU (b_reg, a_reg) and writes b_reg <= o_out_sub.
//    Increment the step count, then go to CMP.
//  - DONE: o_done=1 for exactly one cycle; o_result, o_steps and o_err update
//    in this cycle. Unconditionally return to IDLE.
//  - i_start is ignored in CMP, SUB and DONE; it is never queued.
//    A new start is accepted on the first IDLE cycle after DONE.
//  - Latency from the accept edge to o_done high:
//      2*S+2 cycles, where S = number of subtractions (nonzero operands)
//      1 cycle for a zero-operand case
//  - Width: S <= 2^BITS-2, so o_steps never wraps. All arithmetic is mod 2^BITS.
//    Operands are always nonzero in CMP/SUB, so the loop terminates.
//  - In IDLE and DONE the ALU inputs are driven with a_reg and b_reg; the results are unused.
// TESTING
//  1 a=48, b=18 -> o_done 10 cycles after accept; o_result=6, o_steps=4, o_err=0
//  2 a=7, b=7 -> o_done 2 cycles after accept; o_result=7, o_steps=0
//  3 a=255, b=1 -> o_done 510 cycles after accept; o_result=1, o_steps=254, no wrap
//  4 a=0, b=9 -> o_done 1 cycle after accept, o_result=9, o_err=0;
//    a=0, b=0 -> o_result=0, o_err=1
//  5 i_start pulsed while busy (a=12, b=8 job) -> ignored; o_result=4, o_steps=2,
//    exactly one o_done pulse
//  6 i_rst asserted during SUB -> next cycle IDLE with all outputs 0, no o_done;
//    a new start then completes normally

Source files
------------

// File: rtl/gcd_sequencer.sv
// GCD controller: drives one subtract/compare ALU through Euclid's repeated
// subtraction, one compare or one subtract per clock, with a start/done handshake.

module gcd_alu #(
    parameter int BITS = 8
) (
    input  logic [BITS-1:0] i_a,
    input  logic [BITS-1:0] i_b,
    input  logic            i_carry,
    output logic [BITS-1:0] o_out_sub,
    output logic            o_carry
);
    logic [BITS:0] diff;

    // One extra bit catches the borrow out of the subtraction.
    assign diff      = {1'b0, i_a} - {1'b0, i_b} - {{BITS{1'b0}}, i_carry};
    assign o_out_sub = diff[BITS-1:0];
    assign o_carry   = diff[BITS];
endmodule

module gcd_sequencer #(
    parameter int BITS = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [BITS-1:0] i_a,
    input  logic [BITS-1:0] i_b,
    output logic            o_busy,
    output logic            o_done,
    output logic [BITS-1:0] o_result,
    output logic [BITS-1:0] o_steps,
    output logic            o_err
);
    typedef enum logic [1:0] {S_IDLE, S_CMP, S_SUB, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [BITS-1:0] a_q, a_d;
    logic [BITS-1:0] b_q, b_d;
    logic            dir_q, dir_d;
    logic [BITS-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [BITS-1:0] result_q, result_d;
    logic [BITS-1:0] steps_q, steps_d;
    logic            err_q, err_d;

    logic [BITS-1:0] alu_a, alu_b, alu_diff;
    logic            alu_borrow;

    gcd_alu #(.BITS(BITS)) u_alu (
        .i_a       (alu_a),
        .i_b       (alu_b),
        .i_carry   (1'b0),
        .o_out_sub (alu_diff),
        .o_carry   (alu_borrow)
    );

    // The larger operand goes on the ALU minuend only while subtracting with B larger.
    always_comb begin
        alu_a = a_q;
        alu_b = b_q;
        if (state_q == S_SUB && dir_q) begin
            alu_a = b_q;
            alu_b = a_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        result_d = result_q;
        steps_d  = steps_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    a_d   = i_a;
                    b_d   = i_b;
                    cnt_d = '0;
                    state_d = (i_a == '0 || i_b == '0) ? S_DONE : S_CMP;
                end
            end
            S_CMP: begin
                if (!alu_borrow && alu_diff == '0) begin
                    state_d = S_DONE;
                end else begin
                    dir_d   = alu_borrow;
                    state_d = S_SUB;
                end
            end
            S_SUB: begin
                if (dir_q) begin
                    b_d = alu_diff;
                end else begin
                    a_d = alu_diff;
                end
                cnt_d   = cnt_q + 1'b1;
                state_d = S_CMP;
            end
            S_DONE: begin
                // Either the operands are equal or at most one is nonzero, so OR yields the GCD.
                done_d   = 1'b1;
                result_d = a_q | b_q;
                steps_d  = cnt_q;
                err_d    = (a_q == '0) && (b_q == '0);
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_CMP) || (state_d == S_SUB);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            dir_q    <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            steps_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            dir_q    <= dir_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            steps_q  <= steps_d;
            err_q    <= err_d;
        end
    end

    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_result = result_q;
    assign o_steps  = steps_q;
    assign o_err    = err_q;
endmodule

// File: tb/tb_gcd_sequencer.sv
// Bench for gcd_sequencer: a per-cycle scoreboard driven by a modulo-Euclid
// model, directed cases with literal expectations, then randomized jobs.

module tb_gcd_sequencer;
    logic       clk;
    logic       i_rst;
    logic       i_start;
    logic [7:0] i_a;
    logic [7:0] i_b;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_result;
    logic [7:0] o_steps;
    logic       o_err;

    int tests = 0;
    int fails = 0;

    gcd_sequencer #(.BITS(8)) dut (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_start  (i_start),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_result (o_result),
        .o_steps  (o_steps),
        .o_err    (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Subtraction count = sum of Euclid quotients minus the final one that would reach zero.
    task automatic model(input int a, input int b, output int res, output int steps,
                         output int err, output int lat);
        int x, y;
        if (a == 0 || b == 0) begin
            res = a + b; steps = 0; err = (a == 0 && b == 0) ? 1 : 0; lat = 1;
        end else begin
            x = a; y = b; steps = 0;
            while (y != 0) begin
                int t;
                steps += x / y;
                t = x % y; x = y; y = t;
            end
            steps -= 1;
            res = x; err = 0; lat = 2 * steps + 2;
        end
    endtask

    // Scoreboard: at each negedge check the current cycle, then predict the next one.
    bit m_valid = 0, m_active = 0;
    int m_j, m_lat, m_res, m_steps, m_err;
    bit e_busy, e_done;
    int h_res, h_steps, h_err;

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("busy", int'(o_busy), int'(e_busy));
                chk("done", int'(o_done), int'(e_done));
                chk("result", int'(o_result), h_res);
                chk("steps", int'(o_steps), h_steps);
                chk("err", int'(o_err), h_err);
            end
            if (i_rst) begin
                m_valid = 1; m_active = 0; e_busy = 0; e_done = 0;
                h_res = 0; h_steps = 0; h_err = 0;
            end else if ((!m_active || m_j == m_lat) && i_start) begin
                model(int'(i_a), int'(i_b), m_res, m_steps, m_err, m_lat);
                m_active = 1; m_j = 0; e_done = 0;
                e_busy = (i_a != 0 && i_b != 0);
            end else if (m_active && m_j < m_lat) begin
                m_j++;
                e_busy = (m_j <= m_lat - 2);
                e_done = (m_j == m_lat);
                if (e_done) begin
                    h_res = m_res; h_steps = m_steps; h_err = m_err;
                end
            end else begin
                m_active = 0; e_busy = 0; e_done = 0;
            end
        end
    end

    // Called at posedge+2 with the DUT idle; returns at posedge+2 of the o_done cycle.
    task automatic run_job(input int a, input int b, input bit extra, output int lat,
                           output int res, output int steps, output int err);
        int ml, mr, ms, me;
        model(a, b, mr, ms, me, ml);
        i_start = 1'b1; i_a = 8'(a); i_b = 8'(b);
        @(posedge clk); #2;
        i_start = 1'b0;
        lat = -1;
        for (int k = 0; k <= 600; k++) begin
            if (o_done) begin
                lat = k;
                break;
            end
            if (extra && (k == 2 || k == ml - 1)) begin
                i_start = 1'b1; i_a = 8'd200; i_b = 8'd3;
            end else begin
                i_start = 1'b0;
            end
            @(posedge clk); #2;
        end
        i_start = 1'b0;
        if (lat < 0) chk("done_timeout", lat, ml);
        res = int'(o_result); steps = int'(o_steps); err = int'(o_err);
        $display("[TB] job a=%0d b=%0d -> result=%0d steps=%0d err=%0d latency=%0d",
                 a, b, res, steps, err, lat);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, res, steps, err;
        int mr, ms, me, ml;
        i_rst = 1'b1; i_start = 1'b0; i_a = '0; i_b = '0;
        repeat (3) @(posedge clk);
        #2 i_rst = 1'b0;
        chk("reset_busy", int'(o_busy), 0);
        chk("reset_done", int'(o_done), 0);
        chk("reset_result", int'(o_result), 0);
        chk("reset_steps", int'(o_steps), 0);
        chk("reset_err", int'(o_err), 0);

        model(48, 18, mr, ms, me, ml);
        chk("pin_48_18_res", mr, 6);  chk("pin_48_18_steps", ms, 4);  chk("pin_48_18_lat", ml, 10);
        model(255, 1, mr, ms, me, ml);
        chk("pin_255_1_steps", ms, 254); chk("pin_255_1_lat", ml, 510);
        model(0, 0, mr, ms, me, ml);
        chk("pin_0_0_err", me, 1);    chk("pin_0_0_lat", ml, 1);

        run_job(48, 18, 0, lat, res, steps, err);
        chk("t1_lat", lat, 10); chk("t1_res", res, 6); chk("t1_steps", steps, 4); chk("t1_err", err, 0);
        run_job(7, 7, 0, lat, res, steps, err);
        chk("t2_lat", lat, 2); chk("t2_res", res, 7); chk("t2_steps", steps, 0);
        run_job(255, 1, 0, lat, res, steps, err);
        chk("t3_lat", lat, 510); chk("t3_res", res, 1); chk("t3_steps", steps, 254);
        run_job(0, 9, 0, lat, res, steps, err);
        chk("t4a_lat", lat, 1); chk("t4a_res", res, 9); chk("t4a_err", err, 0);
        run_job(0, 0, 0, lat, res, steps, err);
        chk("t4b_lat", lat, 1); chk("t4b_res", res, 0); chk("t4b_err", err, 1);
        run_job(12, 8, 1, lat, res, steps, err);
        chk("t5_lat", lat, 6); chk("t5_res", res, 4); chk("t5_steps", steps, 2);
        @(posedge clk); #2;
        chk("t5_no_second_done", int'(o_done), 0);

        // Reset in the middle of a long job, landing in a SUB cycle.
        i_start = 1'b1; i_a = 8'd100; i_b = 8'd3;
        @(posedge clk); #2;
        i_start = 1'b0;
        repeat (3) @(posedge clk);
        #2 i_rst = 1'b1;
        @(posedge clk); #2;
        i_rst = 1'b0;
        chk("t6_busy", int'(o_busy), 0);
        chk("t6_result", int'(o_result), 0);
        chk("t6_steps", int'(o_steps), 0);
        chk("t6_err", int'(o_err), 0);
        for (int k = 0; k < 80; k++) begin
            chk("t6_no_done", int'(o_done), 0);
            @(posedge clk); #2;
        end
        run_job(100, 3, 0, lat, res, steps, err);
        chk("t6_res", res, 1); chk("t6_steps", steps, 35); chk("t6_lat", lat, 72);

        for (int n = 0; n < 40; n++) begin
            int a, b, r;
            r = $urandom_range(0, 9);
            a = (r == 0) ? 0 : (r < 4) ? $urandom_range(1, 15) : $urandom_range(1, 255);
            r = $urandom_range(0, 9);
            b = (r == 0) ? 0 : (r < 4) ? $urandom_range(1, 15) : $urandom_range(1, 255);
            model(a, b, mr, ms, me, ml);
            run_job(a, b, (n % 5) == 0, lat, res, steps, err);
            chk("rand_lat", lat, ml); chk("rand_res", res, mr);
            chk("rand_steps", steps, ms); chk("rand_err", err, me);
        end

        @(posedge clk); #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
